// File: rtl/ucsbece154b_mem_arbiter.sv
// Two-port (icache/dcache) line-fill arbiter in front of a single SDRAM read port.
// Round-robin on contention; one burst of BLOCK_WORDS beats in flight at a time.
module ucsbece154b_mem_arbiter #(
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        I_ReadRequest,
  input  logic [31:0] I_ReadAddress,
  output logic [31:0] I_DataOut,
  output logic        I_DataReady,
  output logic        I_DataLast,
  input  logic        D_ReadRequest,
  input  logic [31:0] D_ReadAddress,
  output logic [31:0] D_DataOut,
  output logic        D_DataReady,
  output logic        D_DataLast,
  output logic [31:0] MemReadAddress,
  output logic        MemReadRequest,
  input  logic [31:0] MemDataIn,
  input  logic        MemDataReady,
  output logic [1:0]  Grant,
  output logic        Busy
);

  localparam int unsigned BEAT_W   = $clog2(BLOCK_WORDS);
  localparam int unsigned OFFSET_W = BEAT_W + 2;
  localparam logic [31:0] LINE_MASK = ~((32'(1) << OFFSET_W) - 32'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [31:0]         addr_q, addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                ptr_q, ptr_d;      // 0 = icache next on contention, 1 = dcache
  logic                pick_d;
  logic                last_beat;

  assign last_beat = (state_q == BURST) && MemDataReady && (beat_q == LAST_BEAT);

  // State and burst-context registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      addr_q  <= 32'd0;
      beat_q  <= '0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: arbitrate in IDLE, count beats in BURST
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    pick_d  = D_ReadRequest & (~I_ReadRequest | ptr_q);
    unique case (state_q)
      IDLE: begin
        if (I_ReadRequest || D_ReadRequest) begin
          state_d = BURST;
          grant_d = pick_d ? 2'b10 : 2'b01;
          addr_d  = (pick_d ? D_ReadAddress : I_ReadAddress) & LINE_MASK;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (MemDataReady) begin
          beat_d = beat_q + BEAT_W'(1);
        end
        if (last_beat) begin
          state_d = IDLE;
          grant_d = 2'b00;
          // point at whoever was not just served
          ptr_d   = grant_q[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: beat routing to the granted side only
  always_comb begin
    I_DataOut   = 32'd0;
    I_DataReady = 1'b0;
    I_DataLast  = 1'b0;
    D_DataOut   = 32'd0;
    D_DataReady = 1'b0;
    D_DataLast  = 1'b0;
    if (state_q == BURST) begin
      if (grant_q[0]) begin
        I_DataOut   = MemDataIn;
        I_DataReady = MemDataReady;
        I_DataLast  = last_beat;
      end
      if (grant_q[1]) begin
        D_DataOut   = MemDataIn;
        D_DataReady = MemDataReady;
        D_DataLast  = last_beat;
      end
    end
  end

  assign MemReadRequest = (state_q == BURST);
  assign Busy           = (state_q == BURST);
  assign Grant          = grant_q;
  assign MemReadAddress = addr_q;

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Scoreboard bench for ucsbece154b_mem_arbiter: stimulus queues expected grants/beats,
// a forked monitor pops and compares whenever the arbiter grants or forwards a beat.
module tb_ucsbece154b_mem_arbiter;

  localparam int BW = 4;

  logic        Clk, Reset;
  logic        I_ReadRequest, D_ReadRequest;
  logic [31:0] I_ReadAddress, D_ReadAddress;
  logic [31:0] I_DataOut, D_DataOut;
  logic        I_DataReady, I_DataLast, D_DataReady, D_DataLast;
  logic [31:0] MemReadAddress, MemDataIn;
  logic        MemReadRequest, MemDataReady;
  logic [1:0]  Grant;
  logic        Busy;

  ucsbece154b_mem_arbiter #(.BLOCK_WORDS(BW)) dut (
    .Clk(Clk), .Reset(Reset),
    .I_ReadRequest(I_ReadRequest), .I_ReadAddress(I_ReadAddress),
    .I_DataOut(I_DataOut), .I_DataReady(I_DataReady), .I_DataLast(I_DataLast),
    .D_ReadRequest(D_ReadRequest), .D_ReadAddress(D_ReadAddress),
    .D_DataOut(D_DataOut), .D_DataReady(D_DataReady), .D_DataLast(D_DataLast),
    .MemReadAddress(MemReadAddress), .MemReadRequest(MemReadRequest),
    .MemDataIn(MemDataIn), .MemDataReady(MemDataReady),
    .Grant(Grant), .Busy(Busy)
  );

  typedef struct packed { logic side; logic [31:0] data; logic last; } beat_t;
  typedef struct packed { logic [1:0] grant; logic [31:0] addr; } grant_t;

  beat_t  beat_q[$];
  grant_t grant_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  logic   busy_prev = 1'b0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    I_ReadRequest = 1'b0; D_ReadRequest = 1'b0;
    I_ReadAddress = 32'd0; D_ReadAddress = 32'd0;
    MemDataIn = 32'd0; MemDataReady = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    @(negedge Clk);
    check({tag, "_busy"},    32'(Busy), 32'd0);
    check({tag, "_grant"},   32'(Grant), 32'd0);
    check({tag, "_memreq"},  32'(MemReadRequest), 32'd0);
    check({tag, "_ready"},   32'({I_DataReady, D_DataReady, I_DataLast, D_DataLast}), 32'd0);
    check({tag, "_dataout"}, I_DataOut | D_DataOut, 32'd0);
  endtask

  // Drive a MemDataReady pattern; each accepted beat carries base+beat_index.
  task automatic run_beats(input logic side, input logic [31:0] line, input logic [31:0] base,
                           input logic [15:0] pat, input int len);
    int beat;
    beat = 0;
    for (int i = 0; i < len; i++) begin
      MemDataReady = pat[i];
      if (pat[i]) begin
        MemDataIn = base + 32'(beat);
        beat_q.push_back('{side, MemDataIn, (beat == BW - 1)});
        beat++;
      end else begin
        MemDataIn = 32'hDEAD_BEEF;
      end
      @(negedge Clk);
      check("burst_memreq", 32'(MemReadRequest), 32'd1);
      check("burst_addr", MemReadAddress, line);
      check("burst_grant", 32'(Grant), side ? 32'd2 : 32'd1);
      tick();
    end
    MemDataReady = 1'b0;
    MemDataIn = 32'd0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge Clk);
        if (Busy && !busy_prev) begin
          if (grant_q.size() == 0) begin
            check("unexpected_grant", 32'(Grant), 32'd0);
          end else begin
            grant_t g;
            g = grant_q.pop_front();
            check("grant_onehot", 32'(Grant), 32'(g.grant));
            check("grant_addr", MemReadAddress, g.addr);
          end
        end
        busy_prev = Busy;
        if (I_DataReady || D_DataReady) begin
          if (beat_q.size() == 0) begin
            check("unexpected_beat", 32'({I_DataReady, D_DataReady}), 32'd0);
          end else begin
            beat_t b;
            b = beat_q.pop_front();
            check("beat_side", 32'({D_DataReady, I_DataReady}), b.side ? 32'd2 : 32'd1);
            check("beat_data", b.side ? D_DataOut : I_DataOut, b.data);
            check("beat_last", 32'(b.side ? D_DataLast : I_DataLast), 32'(b.last));
            check("other_side", b.side ? {I_DataOut[30:0], I_DataLast} : {D_DataOut[30:0], D_DataLast}, 32'd0);
          end
        end
      end
    join_none

    do_reset();
    check_quiet("reset");
    check("reset_addr", MemReadAddress, 32'd0);

    // Single icache fill
    I_ReadRequest = 1'b1; I_ReadAddress = 32'h0000_1234;
    grant_q.push_back('{2'b01, 32'h0000_1230});
    tick();
    run_beats(1'b0, 32'h0000_1230, 32'h0000_00A0, 16'h000F, 4);
    I_ReadRequest = 1'b0;
    check_quiet("after_i");

    // Contention after reset: I first, D one cycle after I's last beat, then I again
    do_reset();
    I_ReadRequest = 1'b1; I_ReadAddress = 32'h2000_0048;
    D_ReadRequest = 1'b1; D_ReadAddress = 32'h3000_00F4;
    grant_q.push_back('{2'b01, 32'h2000_0040});
    tick();
    run_beats(1'b0, 32'h2000_0040, 32'h0000_0010, 16'h000F, 4);
    I_ReadRequest = 1'b0;
    grant_q.push_back('{2'b10, 32'h3000_00F0});
    check_quiet("regrant_gap");
    #1;
    run_beats(1'b1, 32'h3000_00F0, 32'h0000_0020, 16'h000F, 4);
    D_ReadRequest = 1'b0;
    tick();
    I_ReadRequest = 1'b1; I_ReadAddress = 32'h0000_0504;
    D_ReadRequest = 1'b1; D_ReadAddress = 32'h0000_0604;
    grant_q.push_back('{2'b01, 32'h0000_0500});
    tick();
    run_beats(1'b0, 32'h0000_0500, 32'h0000_0030, 16'h000F, 4);
    I_ReadRequest = 1'b0;
    // pointer now favours D
    grant_q.push_back('{2'b10, 32'h0000_0600});
    tick();
    run_beats(1'b1, 32'h0000_0600, 32'h0000_0040, 16'h000F, 4);
    D_ReadRequest = 1'b0;
    tick();

    // Back-to-back D-only requests with pointer at I
    D_ReadRequest = 1'b1; D_ReadAddress = 32'h0000_0100;
    grant_q.push_back('{2'b10, 32'h0000_0100});
    tick();
    run_beats(1'b1, 32'h0000_0100, 32'h0000_0050, 16'h000F, 4);
    D_ReadRequest = 1'b0;
    tick();
    D_ReadRequest = 1'b1; D_ReadAddress = 32'h0000_0208;
    grant_q.push_back('{2'b10, 32'h0000_0200});
    tick();
    run_beats(1'b1, 32'h0000_0200, 32'h0000_0060, 16'h000F, 4);
    D_ReadRequest = 1'b0;
    tick();

    // Stray MemDataReady in IDLE, then stalled burst with request/address churn
    MemDataReady = 1'b1; MemDataIn = 32'h0000_0099;
    check_quiet("idle_stray");
    #1;
    MemDataReady = 1'b0;
    D_ReadRequest = 1'b1; D_ReadAddress = 32'h0000_0C3C;
    grant_q.push_back('{2'b10, 32'h0000_0C30});
    tick();
    D_ReadAddress = 32'hFFFF_FFF0;
    I_ReadRequest = 1'b1; I_ReadAddress = 32'h5555_0000;
    run_beats(1'b1, 32'h0000_0C30, 32'h0000_00B0, 16'h0059, 7);
    D_ReadRequest = 1'b0; I_ReadRequest = 1'b0;
    check_quiet("after_stall");
    #1;

    // Reset after beat 2, stray beats ignored, fresh D burst counts from 0
    D_ReadRequest = 1'b1; D_ReadAddress = 32'h0000_4444;
    grant_q.push_back('{2'b10, 32'h0000_4440});
    tick();
    run_beats(1'b1, 32'h0000_4440, 32'h0000_00C0, 16'h0003, 2);
    Reset = 1'b1; D_ReadRequest = 1'b0;
    tick();
    Reset = 1'b0;
    MemDataReady = 1'b1; MemDataIn = 32'h0000_0077;
    check_quiet("post_reset");
    check("post_reset_addr", MemReadAddress, 32'd0);
    #1;
    check_quiet("post_reset2");
    #1;
    MemDataReady = 1'b0;
    D_ReadRequest = 1'b1; D_ReadAddress = 32'h0000_8888;
    grant_q.push_back('{2'b10, 32'h0000_8880});
    tick();
    run_beats(1'b1, 32'h0000_8880, 32'h0000_00D0, 16'h000F, 4);
    D_ReadRequest = 1'b0;
    check_quiet("final");

    tick();
    check("beats_left", 32'(beat_q.size()), 32'd0);
    check("grants_left", 32'(grant_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
